// File: rtl/tcb_peri_gpio_drv.sv
`default_nettype none
// ============================================================================
// Module   : tcb_peri_gpio_drv
// Brief    : GPIO output/enable driver with masked write/set/clear/toggle and
//            timed pulse commands over a valid/ready port; pad outputs are flops.
// Revision : 1.0
// ============================================================================
module tcb_peri_gpio_drv #(
  parameter int unsigned    DAT   = 32,
  parameter int unsigned    CNT   = 16,
  parameter logic [DAT-1:0] RST_O = '0,
  parameter logic [DAT-1:0] RST_E = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [2:0]     cmd_op,
  input  logic [DAT-1:0] cmd_msk,
  input  logic [DAT-1:0] cmd_dat,
  input  logic [CNT-1:0] cmd_len,
  output logic [DAT-1:0] gpio_o,
  output logic [DAT-1:0] gpio_e,
  output logic           busy
);

  localparam logic [2:0]     OP_WRO  = 3'd0;
  localparam logic [2:0]     OP_WRE  = 3'd1;
  localparam logic [2:0]     OP_SET  = 3'd2;
  localparam logic [2:0]     OP_CLR  = 3'd3;
  localparam logic [2:0]     OP_TGL  = 3'd4;
  localparam logic [2:0]     OP_PLS  = 3'd5;
  localparam logic [CNT-1:0] CNT_ONE = {{(CNT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CNT-1:0] cnt_q, cnt_d;
  logic [DAT-1:0] pmsk_q, pmsk_d;
  logic [DAT-1:0] gpio_o_q, gpio_o_d;
  logic [DAT-1:0] gpio_e_q, gpio_e_d;
  logic           xfer;

  assign cmd_rdy = (state_q == ST_IDLE);
  assign busy    = ~cmd_rdy;
  assign xfer    = cmd_vld & cmd_rdy;
  assign gpio_o  = gpio_o_q;
  assign gpio_e  = gpio_e_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pmsk_d   = pmsk_q;
    gpio_o_d = gpio_o_q;
    gpio_e_d = gpio_e_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (cmd_op)
            OP_WRO: gpio_o_d = (gpio_o_q & ~cmd_msk) | (cmd_dat & cmd_msk);
            OP_WRE: gpio_e_d = (gpio_e_q & ~cmd_msk) | (cmd_dat & cmd_msk);
            OP_SET: gpio_o_d = gpio_o_q | cmd_msk;
            OP_CLR: gpio_o_d = gpio_o_q & ~cmd_msk;
            OP_TGL: gpio_o_d = gpio_o_q ^ cmd_msk;
            OP_PLS: begin
              // A zero-length or empty-mask pulse is a no-op, never enters PULSE.
              if ((cmd_len != '0) && (cmd_msk != '0)) begin
                gpio_o_d = gpio_o_q ^ cmd_msk;
                pmsk_d   = cmd_msk;
                cnt_d    = cmd_len;
                state_d  = ST_PULSE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_ONE) begin
          gpio_o_d = gpio_o_q ^ pmsk_q;
          pmsk_d   = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pmsk_q   <= '0;
      gpio_o_q <= RST_O;
      gpio_e_q <= RST_E;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pmsk_q   <= pmsk_d;
      gpio_o_q <= gpio_o_d;
      gpio_e_q <= gpio_e_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcb_peri_gpio_drv.sv
`default_nettype none
// Bench for tcb_peri_gpio_drv: vector table, hand-written pulse/reset sequences,
// and randomized traffic against a cycle-stamped behavioural model.
module tb_tcb_peri_gpio_drv;

  localparam int unsigned    DAT   = 8;
  localparam int unsigned    CNT   = 16;
  localparam logic [DAT-1:0] RST_O = 8'hA5;
  localparam logic [DAT-1:0] RST_E = 8'h0F;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_vld = 1'b0;
  logic           cmd_rdy;
  logic [2:0]     cmd_op = 3'd0;
  logic [DAT-1:0] cmd_msk = '0;
  logic [DAT-1:0] cmd_dat = '0;
  logic [CNT-1:0] cmd_len = '0;
  logic [DAT-1:0] gpio_o;
  logic [DAT-1:0] gpio_e;
  logic           busy;

  tcb_peri_gpio_drv #(
    .DAT(DAT), .CNT(CNT), .RST_O(RST_O), .RST_E(RST_E)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_msk(cmd_msk), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
    .gpio_o(gpio_o), .gpio_e(gpio_e), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: a pulse is an absolute end cycle plus the saved pre-pulse value.
  int unsigned    cyc = 0;
  bit             m_pulse = 1'b0;
  int unsigned    m_end = 0;
  logic [DAT-1:0] m_pre = '0;
  logic [DAT-1:0] m_o = RST_O;
  logic [DAT-1:0] m_e = RST_E;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pulse = 1'b0;
    m_o     = RST_O;
    m_e     = RST_E;
  endtask

  task automatic model_edge();
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (m_pulse) begin
      if (cyc == m_end) begin
        m_o     = m_pre;
        m_pulse = 1'b0;
      end
    end else if (cmd_vld) begin
      case (cmd_op)
        3'd0: for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_o[b] = cmd_dat[b];
        3'd1: for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_e[b] = cmd_dat[b];
        3'd2: for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_o[b] = 1'b1;
        3'd3: for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_o[b] = 1'b0;
        3'd4: for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_o[b] = ~m_o[b];
        3'd5: if (cmd_len != 0 && cmd_msk != 0) begin
          m_pre   = m_o;
          for (int b = 0; b < DAT; b++) if (cmd_msk[b]) m_o[b] = ~m_o[b];
          m_pulse = 1'b1;
          m_end   = cyc + int'(cmd_len);
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gpio_o"}, 32'(gpio_o), 32'(m_o));
    chk({tag, ".gpio_e"}, 32'(gpio_e), 32'(m_e));
    chk({tag, ".rdy"},    32'(cmd_rdy), 32'(!m_pulse));
    chk({tag, ".busy"},   32'(busy),    32'(m_pulse));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] msk,
                       input logic [7:0] dat, input logic [15:0] len);
    cmd_vld = v; cmd_op = op; cmd_msk = msk; cmd_dat = dat; cmd_len = len;
  endtask

  task automatic expect_o(input string nm, input logic [7:0] eo, input logic erdy);
    chk({nm, ".o"},   32'(gpio_o), 32'(eo));
    chk({nm, ".rdy"}, 32'(cmd_rdy), 32'(erdy));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  msk;
    logic [7:0]  dat;
    logic [15:0] len;
    logic [7:0]  eo;
    logic [7:0]  ee;
    logic        erdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3'd0, 8'hFF, 8'h00, 16'd0, 8'h00, 8'h0F, 1'b1};
    tbl[1]  = '{3'd0, 8'hF0, 8'hA5, 16'd0, 8'hA0, 8'h0F, 1'b1};
    tbl[2]  = '{3'd2, 8'h03, 8'h00, 16'd0, 8'hA3, 8'h0F, 1'b1};
    tbl[3]  = '{3'd3, 8'h80, 8'h00, 16'd0, 8'h23, 8'h0F, 1'b1};
    tbl[4]  = '{3'd4, 8'hFF, 8'h00, 16'd0, 8'hDC, 8'h0F, 1'b1};
    tbl[5]  = '{3'd1, 8'hFF, 8'h3C, 16'd0, 8'hDC, 8'h3C, 1'b1};
    tbl[6]  = '{3'd6, 8'hFF, 8'hFF, 16'd5, 8'hDC, 8'h3C, 1'b1};
    tbl[7]  = '{3'd7, 8'hFF, 8'hFF, 16'd5, 8'hDC, 8'h3C, 1'b1};
    tbl[8]  = '{3'd5, 8'h01, 8'h00, 16'd0, 8'hDC, 8'h3C, 1'b1};
    tbl[9]  = '{3'd5, 8'h00, 8'h00, 16'd3, 8'hDC, 8'h3C, 1'b1};
    tbl[10] = '{3'd1, 8'h0F, 8'h00, 16'd0, 8'hDC, 8'h30, 1'b1};
    tbl[11] = '{3'd0, 8'h0F, 8'hFF, 16'd0, 8'hDF, 8'h30, 1'b1};

    // Reset held, then released between edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.o",    32'(gpio_o),  32'h0000_00A5);
    chk("rst.e",    32'(gpio_e),  32'h0000_000F);
    chk("rst.rdy",  32'(cmd_rdy), 32'h1);
    chk("rst.busy", 32'(busy),    32'h0);
    #3 rst = 1'b1;
    step("post_rst");

    // Back-to-back table, one transfer per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].msk, tbl[i].dat, tbl[i].len);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.o", i),   32'(gpio_o),  32'(tbl[i].eo));
      chk($sformatf("tbl%0d.e", i),   32'(gpio_e),  32'(tbl[i].ee));
      chk($sformatf("tbl%0d.rdy", i), 32'(cmd_rdy), 32'(tbl[i].erdy));
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 16'd0);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst.o",   32'(gpio_o),  32'h0000_00A5);
    chk("arst.e",   32'(gpio_e),  32'h0000_000F);
    chk("arst.rdy", 32'(cmd_rdy), 32'h1);
    #2 rst = 1'b1;

    // PLS 01 len 3 from 10, TGL 80 held valid during the pulse.
    drive(1'b1, 3'd0, 8'hFF, 8'h10, 16'd0); step("pre_pls");
    drive(1'b1, 3'd5, 8'h01, 8'h00, 16'd3); step("pls_T");   expect_o("pls_T",  8'h11, 1'b0);
    drive(1'b1, 3'd4, 8'h80, 8'h00, 16'd0); step("pls_T1");  expect_o("pls_T1", 8'h11, 1'b0);
    step("pls_T2"); expect_o("pls_T2", 8'h11, 1'b0);
    step("pls_T3"); expect_o("pls_T3", 8'h10, 1'b1);
    step("pls_T4"); expect_o("pls_T4", 8'h90, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 16'd0); step("pls_idle");

    // PLS FF len 1 from 55.
    drive(1'b1, 3'd0, 8'hFF, 8'h55, 16'd0); step("pre_p1");
    drive(1'b1, 3'd5, 8'hFF, 8'h00, 16'd1); step("p1_T");  expect_o("p1_T",  8'hAA, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 16'd0); step("p1_T1"); expect_o("p1_T1", 8'h55, 1'b1);

    // PLS FF len 5 aborted by reset in its third cycle: no late restore.
    drive(1'b1, 3'd5, 8'hFF, 8'h00, 16'd5); step("p5_T"); expect_o("p5_T", 8'hAA, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 16'd0);
    step("p5_T1"); step("p5_T2"); expect_o("p5_T2", 8'hAA, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    expect_o("p5_abort", 8'hA5, 1'b1);
    #2 rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("p5_after");
      expect_o($sformatf("p5_after%0d", k), 8'hA5, 1'b1);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), 16'($urandom_range(0, 6)));
      if ($urandom_range(0, 63) == 0) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk_model("rnd_arst");
        #1 rst = 1'b1;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tcb_peri_gpio_drv.md
# tcb_peri_gpio_drv

GPIO output driver for the TCB GPIO controller: the output-direction counterpart of the input synchronizer. It holds the GPIO output data and output-enable registers and applies masked write, set, clear, toggle and timed-pulse commands over a valid/ready command port. All pad-facing outputs come directly from flops so pads see no combinational glitches. It sits between the TCB register decoder and the I/O pad ring.

## Interface

Parameters:
- `DAT`, 32: GPIO data width (number of pins).
- `CNT`, 16: pulse length counter width.
- `RST_O`, '0: reset value of `gpio_o`, `DAT` bits.
- `RST_E`, '0: reset value of `gpio_e`, `DAT` bits.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset; asynchronous, active-low (asserted when 0).
- `cmd_vld`  input  1  command valid.
- `cmd_rdy`  output  1  command ready.
- `cmd_op`  input  3  operation code.
- `cmd_msk`  input  DAT  bit mask selecting the affected pins.
- `cmd_dat`  input  DAT  write data, used by WRO and WRE only.
- `cmd_len`  input  CNT  pulse length in cycles, used by PLS only.
- `gpio_o`  output  DAT  GPIO output data, registered.
- `gpio_e`  output  DAT  GPIO output enable, registered.
- `busy`  output  1  pulse in progress; equals `~cmd_rdy`.

## Operation

- A transfer occurs on a rising `clk` edge when `cmd_vld & cmd_rdy`. No other input is sampled.
- `cmd_op` encoding:
  - 0 WRO: `gpio_o <= (gpio_o & ~msk) | (dat & msk)`
  - 1 WRE: `gpio_e <= (gpio_e & ~msk) | (dat & msk)`
  - 2 SET: `gpio_o <= gpio_o | msk`
  - 3 CLR: `gpio_o <= gpio_o & ~msk`
  - 4 TGL: `gpio_o <= gpio_o ^ msk`
  - 5 PLS: `gpio_o <= gpio_o ^ msk`, hold for `len` cycles, then XOR `msk` again to restore the pre-pulse value.
  - 6, 7: reserved. They are accepted (transfer completes) and change nothing.
- PLS with `len == 0` or `msk == 0`: accepted, no output change, no transition to PULSE.
- State machine:
  - IDLE: `cmd_rdy = 1`. A valid PLS transfer moves the block to PULSE and loads the counter.
  - PULSE: `cmd_rdy = 0`, counter decrements each cycle. When the counter expires, the restore XOR is applied and the block returns to IDLE on the same edge.
- The pulse mask is latched at transfer. Bits outside the mask are never modified during a pulse. `gpio_e` is untouched by every op except WRE.
- `cmd_vld` held high during PULSE: the command waits and is not lost. Any `cmd_*` change while `cmd_rdy = 0` is permitted; the value present when `cmd_rdy` is high is taken.

## Timing

- Reset (`rst = 0`, asynchronous): `gpio_o = RST_O`, `gpio_e = RST_E`, `cmd_rdy = 1`, `busy = 0`, state IDLE, counter 0.
- Reset asserted mid-pulse aborts the pulse. Outputs go to reset values immediately and no restore is applied afterwards.
- Reset deassertion is synchronized by the integrator. The block is ready on the first edge after release.
- Non-pulse ops: transfer on edge T, new output value visible after edge T. Back-to-back transfers every cycle are supported, throughput 1 per cycle.
- PLS with `len = N ≥ 1`, transfer on edge T:
  - masked bits are inverted for exactly N cycles (after edge T through edge T+N);
  - restored value appears after edge T+N;
  - `cmd_rdy` is low after edges T..T+N-1 and high after edge T+N;
  - the earliest next transfer is edge T+N+1.
- Maximum `len = 2^CNT - 1`, with no wrap.
- `cmd_rdy` depends only on state, not on `cmd_vld`.

## Test plan

- Reset release with `RST_O = 'hA5`, `RST_E = 'h0F` (DAT=8) → `gpio_o = A5`, `gpio_e = 0F`, `cmd_rdy = 1`. Then pull `rst` low asynchronously mid-cycle → outputs return to the reset values without waiting for a clock edge.
- Back-to-back (DAT=8, start 00): WRO msk=F0 dat=A5 → 0xA0; SET 03 → A3; CLR 80 → 23; TGL FF → DC; WRE msk=FF dat=3C → `gpio_e = 3C`. One transfer per cycle, each value visible one edge after its transfer.
- PLS msk=01, len=3 from `gpio_o = 10` → `gpio_o = 11` for exactly 3 cycles, then 10. `busy` is high for 3 cycles. A TGL 80 held valid during the pulse is accepted on edge T+4 → `gpio_o = 90`.
- PLS len=0 and PLS msk=0 → accepted, `cmd_rdy` stays 1, `gpio_o` unchanged. Opcodes 6 and 7 → accepted, no change.
- PLS msk=FF len=1 from `gpio_o = 55` → AA for one cycle, then 55. A second PLS len=5 with `rst` asserted at its third cycle → `gpio_o = RST_O` and `cmd_rdy = 1` after release, with no late restore toggle.
